// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/EXEC sequencer gating PC and register-file strobes once per instruction.
// Define SEQ_TIMEOUT_EN to build the load timeout counter and sticky err flag.
module cpu_sequencer #(
    parameter int MUL_CYCLES = 3,
    parameter int LD_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       dec_pcincr,
    input  logic       dec_pcabs,
    input  logic       dec_pcrel,
    input  logic       dec_w,
    input  logic       dec_ld,
    input  logic       dec_mul,
    input  logic       mem_ack,
    output logic       ir_en,
    output logic       pc_incr,
    output logic       pc_abs,
    output logic       pc_rel,
    output logic       reg_we,
    output logic       mul_start,
    output logic       mem_req,
    output logic       busy,
    output logic [1:0] seq_state,
    output logic       err
);
    typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, MUL_WAIT = 2'd2, LD_WAIT = 2'd3} state_t;
    state_t     r_state, w_next;
    logic [3:0] r_mul_cnt;
    logic       w_exec_plain, w_mul_done, w_ld_done, w_ld_abort;

    assign w_exec_plain = r_state == EXEC && !dec_mul && !dec_ld;
    assign w_mul_done   = r_state == MUL_WAIT && r_mul_cnt == 4'd0;
    assign w_ld_done    = r_state == LD_WAIT && mem_ack;

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= FETCH;
        else       r_state <= w_next;

    always_ff @(posedge clk or posedge reset)
        if (reset)                                r_mul_cnt <= 4'd0;
        else if (r_state == EXEC && dec_mul)      r_mul_cnt <= 4'(MUL_CYCLES - 1);
        else if (r_state == MUL_WAIT && !w_mul_done) r_mul_cnt <= r_mul_cnt - 4'd1;

`ifdef SEQ_TIMEOUT_EN
    logic [7:0] r_to_cnt;
    logic       r_err;
    assign w_ld_abort = r_state == LD_WAIT && !mem_ack && r_to_cnt == 8'(LD_TIMEOUT - 1);
    assign err        = r_err;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_to_cnt <= 8'd0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == EXEC)                     r_to_cnt <= 8'd0;
            else if (r_state == LD_WAIT && !mem_ack) r_to_cnt <= r_to_cnt + 8'd1;
            if (w_ld_abort) r_err <= 1'b1;
        end
`else
    assign w_ld_abort = 1'b0;
    assign err        = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:    w_next = run ? EXEC : FETCH;
            EXEC:     w_next = dec_mul ? MUL_WAIT : dec_ld ? LD_WAIT : FETCH;
            MUL_WAIT: w_next = w_mul_done ? FETCH : MUL_WAIT;
            LD_WAIT:  w_next = (w_ld_done || w_ld_abort) ? FETCH : LD_WAIT;
            default:  w_next = FETCH;
        endcase
    end

    // State is forced to FETCH by reset; only ir_en also needs explicit gating.
    always_comb begin
        ir_en     = !reset && r_state == FETCH && run;
        pc_incr   = w_exec_plain ? dec_pcincr : (w_mul_done || w_ld_done || w_ld_abort);
        pc_abs    = w_exec_plain && dec_pcabs;
        pc_rel    = w_exec_plain && dec_pcrel;
        reg_we    = w_exec_plain ? dec_w : (w_mul_done || w_ld_done);
        mul_start = r_state == EXEC && dec_mul;
        mem_req   = (r_state == EXEC && !dec_mul && dec_ld) || r_state == LD_WAIT;
        busy      = r_state != FETCH;
        seq_state = r_state;
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer; define SEQ_TIMEOUT_EN to cover the load timeout.
module tb_cpu_sequencer;
`ifdef SEQ_TIMEOUT_EN
    localparam int LDT = 4;
`else
    localparam int LDT = 15;
`endif
    localparam int MC = 3;

    logic clk = 1'b0;
    logic reset, run, dec_pcincr, dec_pcabs, dec_pcrel, dec_w, dec_ld, dec_mul, mem_ack;
    logic ir_en, pc_incr, pc_abs, pc_rel, reg_we, mul_start, mem_req, busy, err;
    logic [1:0] seq_state;
    logic [10:0] w_obs;
    logic ee = 1'b0;

    typedef struct packed {
        logic [10:0] v;
        logic [7:0]  id;
    } exp_t;
    exp_t sb[$];
    exp_t r_x;
    int n_chk = 0, n_fail = 0, cyc_id = 0;

    cpu_sequencer #(.MUL_CYCLES(MC), .LD_TIMEOUT(LDT)) dut (
        .clk(clk), .reset(reset), .run(run),
        .dec_pcincr(dec_pcincr), .dec_pcabs(dec_pcabs), .dec_pcrel(dec_pcrel),
        .dec_w(dec_w), .dec_ld(dec_ld), .dec_mul(dec_mul), .mem_ack(mem_ack),
        .ir_en(ir_en), .pc_incr(pc_incr), .pc_abs(pc_abs), .pc_rel(pc_rel),
        .reg_we(reg_we), .mul_start(mul_start), .mem_req(mem_req), .busy(busy),
        .seq_state(seq_state), .err(err)
    );

    always #5 clk = ~clk;

    assign w_obs = {ir_en, pc_incr, pc_abs, pc_rel, reg_we, mul_start, mem_req, busy, seq_state, err};

    task automatic chk(input string tag, input logic [10:0] act, input logic [10:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (ir pi pa pr we ms mr busy st[2] err)", tag, act, exp);
        end
    endtask

    function automatic logic [10:0] ev(input logic ir, pi, pa, pr, we, ms, mr,
                                       input logic [1:0] st, input logic e);
        return {ir, pi, pa, pr, we, ms, mr, st != 2'd0, st, e};
    endfunction

    task automatic cyc(input logic r, mul, ld, pi, pa, pr, w, ack, input logic [10:0] e);
        @(posedge clk);
        #1;
        run = r; dec_mul = mul; dec_ld = ld; dec_pcincr = pi;
        dec_pcabs = pa; dec_pcrel = pr; dec_w = w; mem_ack = ack;
        sb.push_back({e, cyc_id[7:0]});
        cyc_id++;
    endtask

    task automatic fetch();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 2'd0, ee));
    endtask

    task automatic idle(input logic ack);
        cyc(0, 0, 0, 1, 1, 1, 1, ack, ev(0, 0, 0, 0, 0, 0, 0, 2'd0, ee));
    endtask

    // Load whose ack arrives in LD_WAIT cycle n; decoder strobes held high must stay gated.
    task automatic do_load(input int n);
        fetch();
        cyc(0, 0, 1, 1, 1, 1, 1, 0, ev(0, 0, 0, 0, 0, 0, 1, 2'd1, ee));
        for (int i = 1; i < n; i++) cyc(0, 0, 0, 1, 1, 1, 1, 0, ev(0, 0, 0, 0, 0, 0, 1, 2'd3, ee));
        cyc(0, 0, 0, 1, 1, 1, 1, 1, ev(0, 1, 0, 0, 1, 0, 1, 2'd3, ee));
    endtask

    always @(negedge clk)
        if (sb.size() != 0) begin
            r_x = sb.pop_front();
            chk($sformatf("cyc%0d", r_x.id), w_obs, r_x.v);
        end

    initial begin
        reset = 0; run = 1; dec_pcincr = 0; dec_pcabs = 0; dec_pcrel = 0;
        dec_w = 0; dec_ld = 0; dec_mul = 0; mem_ack = 0;
        #2 reset = 1;
        #1 chk("rst_async", w_obs, 11'd0);
        #19 reset = 0;
        #1 chk("rst_release", w_obs, ev(1, 0, 0, 0, 0, 0, 0, 2'd0, 1'b0));
        #1 run = 0;
        // ADD: single EXEC cycle with write and increment
        fetch();
        cyc(1, 0, 0, 1, 0, 0, 1, 0, ev(0, 1, 0, 0, 1, 0, 0, 2'd1, ee));
        idle(0);
        // MULTI also flagged as load: multiply wins; stray acks and strobes ignored
        fetch();
        cyc(0, 1, 1, 1, 1, 1, 1, 1, ev(0, 0, 0, 0, 0, 1, 0, 2'd1, ee));
        for (int i = 0; i < MC - 1; i++) cyc(0, 0, 0, 1, 1, 1, 1, 1, ev(0, 0, 0, 0, 0, 0, 0, 2'd2, ee));
        cyc(0, 0, 0, 1, 1, 1, 1, 1, ev(0, 1, 0, 0, 1, 0, 0, 2'd2, ee));
        idle(0);
        // LOAD, then a stray ack in FETCH
`ifdef SEQ_TIMEOUT_EN
        do_load(3);
`else
        do_load(5);
`endif
        idle(1);
        idle(0);
        // BEQ taken, then held in FETCH
        fetch();
        cyc(1, 0, 0, 0, 0, 1, 0, 0, ev(0, 0, 0, 1, 0, 0, 0, 2'd1, ee));
        idle(0);
        idle(0);
        // JMP with link write
        fetch();
        cyc(0, 0, 0, 0, 1, 0, 1, 0, ev(0, 0, 1, 0, 1, 0, 0, 2'd1, ee));
        idle(0);
`ifdef SEQ_TIMEOUT_EN
        fetch();
        cyc(0, 0, 1, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 1, 2'd1, ee));
        for (int i = 1; i < LDT; i++) cyc(0, 0, 0, 1, 1, 1, 1, 0, ev(0, 0, 0, 0, 0, 0, 1, 2'd3, ee));
        cyc(0, 0, 0, 1, 1, 1, 1, 0, ev(0, 1, 0, 0, 0, 0, 1, 2'd3, ee));
        ee = 1;
        idle(0);
        do_load(2);
        idle(0);
`else
        do_load(20);
        idle(0);
`endif
        // Async reset mid LD_WAIT abandons the load
        fetch();
        cyc(0, 0, 1, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 1, 2'd1, ee));
        cyc(0, 0, 0, 1, 1, 1, 1, 0, ev(0, 0, 0, 0, 0, 0, 1, 2'd3, ee));
        @(negedge clk);
        #2 reset = 1; mem_ack = 1;
        #1 chk("rst_ldwait", w_obs, 11'd0);
        @(posedge clk);
        #1 chk("rst_hold", w_obs, 11'd0);
        @(negedge clk);
        #2 reset = 0; run = 0; mem_ack = 0;
        ee = 0;
        #1 chk("rst_rel2", w_obs, 11'd0);
`ifdef SEQ_TIMEOUT_EN
        do_load(LDT);
`else
        do_load(1);
`endif
        idle(0);
        idle(0);
        @(negedge clk);
        #1 chk("sb_empty", 11'(sb.size()), 11'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the processor core. It sits between the combinational instruction decoder and the PC, instruction register and register file, and splits each instruction into FETCH and EXEC phases. Multiply and load instructions are stretched over extra cycles. PC-update and register-write strobes are gated so each fires exactly once per instruction.

Parameters:
MUL_CYCLES, 3, number of wait cycles the multiplier needs after mul_start (legal 1..15)
LD_TIMEOUT, 15, maximum LD_WAIT cycles before abort (used only with SEQ_TIMEOUT_EN; legal 1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  1 = allow fetch of the next instruction; 0 = hold in FETCH
dec_pcincr  in  1  decoder PCincr
dec_pcabs  in  1  decoder PCabsbranch
dec_pcrel  in  1  decoder PCrelbranch
dec_w  in  1  decoder register-write request
dec_ld  in  1  decoder load flag
dec_mul  in  1  1 = current opcode is MULTI
mem_ack  in  1  data memory read complete, single-cycle pulse
ir_en  out  1  instruction register load enable
pc_incr  out  1  gated PC increment
pc_abs  out  1  gated absolute branch
pc_rel  out  1  gated relative branch
reg_we  out  1  gated register-file write enable
mul_start  out  1  one-cycle multiplier start pulse
mem_req  out  1  data memory read request, level
busy  out  1  high whenever state != FETCH
seq_state  out  2  state encoding, for debug
err  out  1  sticky load-timeout flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- State register values: FETCH=0, EXEC=1, MUL_WAIT=2, LD_WAIT=3.
- Reset: state goes to FETCH, both counters clear, err clears. Every output is 0 while reset is high.
- Outputs are combinational decodes of the registered state and current inputs. Any output not listed for a state is 0.
- FETCH:
  - ir_en = run.
  - run=1: go to EXEC next cycle. run=0: stay in FETCH.
- EXEC, priority dec_mul > dec_ld > other:
  - dec_mul: mul_start=1; load the counter with MUL_CYCLES-1; go to MUL_WAIT.
  - dec_ld: mem_req=1; clear the timeout counter; go to LD_WAIT.
  - Otherwise: pc_incr=dec_pcincr, pc_abs=dec_pcabs, pc_rel=dec_pcrel, reg_we=dec_w; go to FETCH.
- MUL_WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter is 0: reg_we=1, pc_incr=1, go to FETCH.
  - Total multiply latency is 2+MUL_CYCLES cycles.
- LD_WAIT:
  - mem_req=1 is held continuously.
  - On mem_ack=1 (combinational): reg_we=1, pc_incr=1, go to FETCH.
  - Minimum load latency is 3 cycles.
- mem_ack in any state other than LD_WAIT is ignored.
- run is sampled only in FETCH. Deasserting run mid-instruction never aborts the instruction.
- Each of pc_incr, pc_abs, pc_rel and reg_we is high for at most one cycle per instruction. pc_abs and pc_rel are never high in the same cycle as a multiply or load completion.
- Counter widths: multiply counter is 4 bits; timeout counter is 8 bits. Neither wraps: each is reloaded on state entry.
- An asynchronous reset during MUL_WAIT or LD_WAIT abandons the instruction. There is no write, no PC change, and mem_req drops immediately.

Optional Feature:
Macro SEQ_TIMEOUT_EN.
- Defined:
  - In LD_WAIT the timeout counter increments each cycle without mem_ack.
  - When the counter equals LD_TIMEOUT-1 and mem_ack=0: pc_incr=1, reg_we=0, err set to 1, go to FETCH.
  - err stays set until reset.
  - mem_ack in that same cycle wins: the load completes normally and err is not set.
- Not defined: LD_WAIT waits indefinitely, the timeout counter is not built, err is tied to 0.

Test Plan:
1. Reset asserted mid-cycle with run=1 -> all outputs 0 asynchronously. After release, seq_state=0 and ir_en=1.
2. ADD: dec_w=1, dec_pcincr=1 -> ir_en in cycle 0; reg_we=1 and pc_incr=1 in cycle 1 only; back in FETCH in cycle 2.
3. MULTI with MUL_CYCLES=3 -> mul_start in cycle 1; reg_we and pc_incr in cycle 4 only; busy high in cycles 1-4.
4. LOAD with mem_ack in the 5th LD_WAIT cycle -> mem_req high for 6 cycles (EXEC plus 5 in LD_WAIT); reg_we with pc_incr in the ack cycle; a stray mem_ack in FETCH has no effect.
5. BEQ taken: dec_pcrel=1, dec_pcincr=0 -> pc_rel=1 and pc_incr=0 in EXEC. With run=0 afterwards, the block holds in FETCH with ir_en=0.
6. SEQ_TIMEOUT_EN with LD_TIMEOUT=4 and no ack -> abort in the 4th LD_WAIT cycle: pc_incr=1, reg_we=0, err=1 sticky. A repeat run with ack in that 4th cycle completes normally and err stays 0.
